// File: rtl/nibble_serial_adsub.sv
// WIDTH-bit add/subtract sequencer: feeds a 4-bit adder-subtractor slice one
// nibble per clock (LSB first), carrying between nibbles, with valid/ready on both sides.
module nibble_serial_adsub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             busy
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  // 4-bit adder-subtractor slice operating on the current nibble
  logic [3:0] nib_a, nib_b;
  logic [4:0] nib_full;
  logic [3:0] nib_low3;
  logic       last_step;

  assign nib_a     = 4'(a_q >> {idx_q, 2'b00});
  assign nib_b     = 4'(b_q >> {idx_q, 2'b00});
  assign nib_full  = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
  // Carry into bit 3 of the slice; on the top nibble this is the carry into the sign bit.
  assign nib_low3  = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b000, carry_q};
  assign last_step = (idx_q == IDXW'(NIB - 1));

  // NOTE: every flop is reset, including the operand latches and the result, so a
  // reset mid-operation leaves no stale data visible on the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (latch).
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_RUN;
      S_RUN:   if (last_step) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // Subtract is a + ~b + 1: invert b once here and seed the carry with the mode.
          a_d     = in_a;
          b_d     = in_b ^ {WIDTH{in_mode}};
          carry_d = in_mode;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        for (int n = 0; n < NIB; n++) begin
          if (idx_q == IDXW'(n)) sum_d[4*n +: 4] = nib_full[3:0];
        end
        carry_d = nib_full[4];
        if (last_step) begin
          idx_d  = '0;
          cout_d = nib_full[4];
          ovf_d  = nib_low3[3] ^ nib_full[4];
          zero_d = (sum_d == '0);
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    out_sum   = sum_q;
    out_cout  = cout_q;
    out_ovf   = ovf_q;
    out_zero  = zero_q;
  end

endmodule

// File: tb/tb_nibble_serial_adsub.sv
// Directed bench for nibble_serial_adsub (WIDTH=16): reset, add/sub results and
// flags, latency, backpressure, and reset in the middle of an operation.
module tb_nibble_serial_adsub;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  nibble_serial_adsub #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait (bounded) for out_valid, check latency and result.
  // Leaves the block in DONE; the caller decides when out_ready lets it go.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic mode, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf, input logic exp_zero);
    int n;
    @(negedge clk);
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_a     = a;
    in_b     = b;
    in_mode  = mode;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
    in_mode  = ~mode;
    n = 0;
    while (n < 12) begin
      @(posedge clk);
      n++;
      #1;
      if (out_valid) break;
    end
    check({tag, ".latency"}, n, NIB);
    check({tag, ".sum"},  {16'd0, out_sum}, {16'd0, exp_sum});
    check({tag, ".cout"}, {31'd0, out_cout}, {31'd0, exp_cout});
    check({tag, ".ovf"},  {31'd0, out_ovf},  {31'd0, exp_ovf});
    check({tag, ".zero"}, {31'd0, out_zero}, {31'd0, exp_zero});
  endtask

  // Complete the output handshake from DONE with out_ready high.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".drain_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".drain_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_mode   = 1'b0;
    out_ready = 1'b1;

    // Reset for two edges, then release
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready",  {31'd0, in_ready},  32'd1);
    check("rst.busy",      {31'd0, busy},      32'd0);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.sum",       {16'd0, out_sum},   32'd0);
    check("rst.flags",     {29'd0, out_cout, out_ovf, out_zero}, 32'd0);

    // Add / subtract patterns
    run_op("add1234", 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0);
    drain("add1234");
    run_op("sub5m7",  16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    drain("sub5m7");
    run_op("subeq",   16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    drain("subeq");
    run_op("addmix",  16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    drain("addmix");

    // Overflow and wrap boundaries
    run_op("addovf",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    drain("addovf");
    run_op("subovf",  16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    drain("subovf");
    run_op("addwrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    drain("addwrap");

    // Backpressure: hold DONE for three cycles while poking the input side
    out_ready = 1'b0;
    run_op("bp", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      in_valid = ~in_valid;
      in_a     = in_a + 16'h1111;
      @(posedge clk);
      #1;
      check("bp.valid", {31'd0, out_valid}, 32'd1);
      check("bp.ready", {31'd0, in_ready},  32'd0);
      check("bp.busy",  {31'd0, busy},      32'd1);
      check("bp.sum",   {16'd0, out_sum},   32'h3);
    end
    in_valid = 1'b0;
    drain("bp");
    check("bp.idle_busy", {31'd0, busy}, 32'd0);
    check("bp.hold_sum",  {16'd0, out_sum}, 32'h3);

    // Reset while RUN is on nibble index 2
    @(negedge clk);
    in_a     = 16'h1111;
    in_b     = 16'h2222;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("rrun.busy",  {31'd0, busy},      32'd0);
    check("rrun.ready", {31'd0, in_ready},  32'd1);
    check("rrun.valid", {31'd0, out_valid}, 32'd0);
    check("rrun.sum",   {16'd0, out_sum},   32'd0);
    check("rrun.flags", {29'd0, out_cout, out_ovf, out_zero}, 32'd0);
    for (int k = 0; k < NIB + 2; k++) begin
      @(posedge clk);
      #1;
      check("rrun.no_valid", {31'd0, out_valid}, 32'd0);
    end
    run_op("postrst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    drain("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
